// File: rtl/rfifo_drain_pkg.sv
// Shared types and constants for the rfifo_drain read-FIFO beat drainer.
package rfifo_drain_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int CNT_W = 32;

endpackage

// File: rtl/rfifo_drain_perf.sv
// Saturating stall-cycle counter for rfifo_drain; only present when RFIFO_DRAIN_PERF_EN is defined.
module rfifo_drain_perf
   import rfifo_drain_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic             stall,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (stall && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/rfifo_drain.sv
// Drains wide show-ahead FIFO entries as BEATS narrow beats, LS beat first.
// Optional stall counter enabled by defining RFIFO_DRAIN_PERF_EN.
//
// state | meaning
// IDLE  | no entry held; pop as soon as the FIFO has one
// SEND  | presenting beat beat_cnt of the held entry
module rfifo_drain
   import rfifo_drain_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int BEATS  = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    fifo_empty,
   input  logic [DWIDTH*BEATS-1:0] fifo_dout,
   output logic                    fifo_re,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [DWIDTH-1:0]       m_data,
   output logic                    m_last,
   output logic                    busy,
   output logic [CNT_W-1:0]        stall_cnt
);

   localparam int CW = $clog2(BEATS);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   state_t                       state, state_nxt;
   logic [CW-1:0]                beat_cnt;
   logic [BEATS-1:0][DWIDTH-1:0] hold;
   logic                         sending;
   logic                         take;

   assign sending = (state == SEND);
   assign take    = sending && m_ready;
   assign m_valid = sending;
   assign busy    = sending;
   assign m_last  = sending && (beat_cnt == LAST_BEAT);
   assign m_data  = sending ? hold[beat_cnt] : '0;

   // Pops are gated by rstn so no entry is lost while reset is held.
   always_comb begin
      state_nxt = state;
      fifo_re   = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_re   = rstn;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (take && m_last) begin
               if (!fifo_empty) begin
                  fifo_re = rstn;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold     <= '0;
         beat_cnt <= '0;
      end else if (fifo_re) begin
         hold     <= fifo_dout;
         beat_cnt <= '0;
      end else if (take && !m_last) begin
         beat_cnt <= beat_cnt + CW'(1);
      end
   end

`ifdef RFIFO_DRAIN_PERF_EN
   rfifo_drain_perf u_perf (
      .clk   (clk),
      .rstn  (rstn),
      .stall (m_valid && !m_ready),
      .cnt   (stall_cnt)
   );
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rfifo_drain.sv
// Self-checking bench for rfifo_drain (DWIDTH=32, BEATS=4): vector table, directed sequences, random scoreboard.
module tb_rfifo_drain;

   localparam int DW = 32;
   localparam int NB = 4;

   logic           clk = 1'b0;
   logic           rstn;
   logic           fifo_empty;
   logic [127:0]   fifo_dout;
   logic           fifo_re;
   logic           m_valid;
   logic           m_ready;
   logic [DW-1:0]  m_data;
   logic           m_last;
   logic           busy;
   logic [31:0]    stall_cnt;

   always #5 clk = ~clk;

   rfifo_drain #(.DWIDTH(DW), .BEATS(NB)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .fifo_re    (fifo_re),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .busy       (busy),
      .stall_cnt  (stall_cnt)
   );

   int tests = 0;
   int fails = 0;
   logic [127:0] q[$];
   logic         re_q;

   typedef struct {
      bit           push;
      logic [127:0] entry;
      logic         ready;
      logic         exp_valid;
      logic [31:0]  exp_data;
      logic         exp_last;
      logic         exp_re;
      logic         exp_busy;
   } vec_t;
   vec_t vt[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic upd();
      fifo_empty = (q.size() == 0);
      fifo_dout  = (q.size() != 0) ? q[0] : '0;
   endtask

   // Advance one clock; the FIFO model pops on the edge if fifo_re was high.
   task automatic tick();
      re_q = fifo_re;
      @(posedge clk);
      #1;
      if (re_q && q.size() != 0) q.delete(0);
      upd();
   endtask

   task automatic do_reset();
      rstn    = 1'b0;
      m_ready = 1'b0;
      q.delete();
      upd();
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   function automatic void add(bit p, logic [127:0] e, logic r, logic v, logic [31:0] d,
                               logic l, logic re, logic b);
      vt.push_back('{p, e, r, v, d, l, re, b});
   endfunction

   function automatic logic [31:0] word_of(logic [127:0] e, int i);
      return e[32*i +: 32];
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [127:0] ents[3];
      logic [127:0] e;
      logic [31:0]  expw[$];
      int           beat_idx;
      int           stalls;
      bit           have_exp;
      logic         exp_v_next;
      int           guard;
      logic [31:0]  exp_stall;

      // Reset state
      rstn = 1'b0; m_ready = 1'b1;
      q.delete();
      q.push_back(128'h1);
      upd();
      #2;
      chk("rst_valid", m_valid, 0);
      chk("rst_last", m_last, 0);
      chk("rst_re", fifo_re, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", m_data, 0);
      chk("rst_stall", stall_cnt, 0);
      do_reset();

      // Vector table: single entry streaming, then a 5-cycle stall on beat 2
      add(1, 128'h44443333_22221111_BBBBAAAA_DDDDCCCC, 1, 0, 32'h0, 0, 1, 0);
      add(0, '0, 1, 1, 32'hDDDDCCCC, 0, 0, 1);
      add(0, '0, 1, 1, 32'hBBBBAAAA, 0, 0, 1);
      add(0, '0, 1, 1, 32'h22221111, 0, 0, 1);
      add(0, '0, 1, 1, 32'h44443333, 1, 0, 1);
      add(0, '0, 1, 0, 32'h0, 0, 0, 0);
      add(1, 128'hA0000003_A0000002_A0000001_A0000000, 1, 0, 32'h0, 0, 1, 0);
      add(0, '0, 1, 1, 32'hA0000000, 0, 0, 1);
      add(0, '0, 1, 1, 32'hA0000001, 0, 0, 1);
      for (int i = 0; i < 5; i++) add(0, '0, 0, 1, 32'hA0000002, 0, 0, 1);
      add(0, '0, 1, 1, 32'hA0000002, 0, 0, 1);
      add(0, '0, 1, 1, 32'hA0000003, 1, 0, 1);
      add(0, '0, 1, 0, 32'h0, 0, 0, 0);

      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].push) begin
            q.push_back(vt[i].entry);
            upd();
         end
         m_ready = vt[i].ready;
         #1;
         chk($sformatf("vec%0d_valid", i), m_valid, vt[i].exp_valid);
         chk($sformatf("vec%0d_data", i), m_data, vt[i].exp_data);
         chk($sformatf("vec%0d_last", i), m_last, vt[i].exp_last);
         chk($sformatf("vec%0d_re", i), fifo_re, vt[i].exp_re);
         chk($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
         tick();
      end
`ifdef RFIFO_DRAIN_PERF_EN
      exp_stall = 32'd5;
`else
      exp_stall = 32'd0;
`endif
      chk("stall_after_hold", stall_cnt, exp_stall);

      // Three preloaded entries drain back-to-back
      do_reset();
      ents[0] = 128'h03000000_02000000_01000000_00000000;
      ents[1] = 128'h13111111_12111111_11111111_10111111;
      ents[2] = 128'h23222222_22222222_21222222_20222222;
      for (int i = 0; i < 3; i++) q.push_back(ents[i]);
      upd();
      m_ready = 1'b1;
      for (int k = 0; k < 14; k++) begin
         #1;
         chk($sformatf("b2b%0d_valid", k), m_valid, (k >= 1 && k <= 12));
         chk($sformatf("b2b%0d_re", k), fifo_re, (k == 0 || k == 4 || k == 8));
         if (k >= 1 && k <= 12) begin
            e = ents[(k-1)/4];
            chk($sformatf("b2b%0d_data", k), m_data, word_of(e, (k-1)%4));
            chk($sformatf("b2b%0d_last", k), m_last, ((k-1)%4 == 3));
         end
         tick();
      end

      // Empty FIFO: nothing happens
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("empty_re", fifo_re, 0);
         chk("empty_valid", m_valid, 0);
         chk("empty_busy", busy, 0);
         tick();
      end

      // Reset mid-entry discards the held entry
      q.push_back(128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000);
      upd();
      m_ready = 1'b1;
      tick();
      tick();
      #1;
      chk("mid_beat1", m_data, 32'hCCCC0001);
      tick();
      rstn = 1'b0;
      q.push_back(128'hDEAD);
      upd();
      #1;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_last", m_last, 0);
      chk("mid_rst_re", fifo_re, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", m_data, 0);
      q.delete();
      upd();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("post_rst_valid", m_valid, 0);
         chk("post_rst_busy", busy, 0);
         chk("post_rst_re", fifo_re, 0);
         tick();
      end

      // Stall counter saturation
      do_reset();
      q.push_back(128'h5);
      upd();
      m_ready = 1'b0;
      tick();
`ifdef RFIFO_DRAIN_PERF_EN
      force dut.u_perf.cnt = 32'hFFFF_FFFE;
      #1;
      release dut.u_perf.cnt;
      for (int k = 0; k < 4; k++) tick();
      #1;
      chk("stall_sat", stall_cnt, 32'hFFFF_FFFF);
`else
      for (int k = 0; k < 4; k++) tick();
      #1;
      chk("stall_tied0", stall_cnt, 32'h0);
`endif
      m_ready = 1'b1;
      for (int k = 0; k < 6; k++) tick();

      // Random traffic against a beat-stream scoreboard
      do_reset();
      expw.delete();
      beat_idx = 0;
      stalls   = 0;
      have_exp = 1'b0;
      exp_v_next = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc < 560 && q.size() < 3 && $urandom_range(0, 2) == 0) begin
            e = {$urandom, $urandom, $urandom, $urandom};
            q.push_back(e);
            for (int w = 0; w < NB; w++) expw.push_back(word_of(e, w));
            upd();
         end
         m_ready = (cyc >= 560) ? 1'b1 : ($urandom_range(0, 3) != 0);
         #1;
         if (have_exp) chk("rnd_valid", m_valid, exp_v_next);
         chk("rnd_busy", busy, m_valid);
         if (fifo_empty) chk("rnd_re_empty", fifo_re, 0);
         if (!m_valid) begin
            exp_v_next = !fifo_empty;
         end else if (m_ready && beat_idx == NB-1) begin
            exp_v_next = !fifo_empty;
         end else begin
            exp_v_next = 1'b1;
         end
         have_exp = 1'b1;
         if (m_valid && !m_ready) stalls++;
         if (m_valid && m_ready) begin
            if (expw.size() == 0) begin
               chk("rnd_extra_beat", 1, 0);
            end else begin
               chk("rnd_data", m_data, expw.pop_front());
            end
            chk("rnd_last", m_last, (beat_idx == NB-1));
            beat_idx = (beat_idx + 1) % NB;
         end
         tick();
      end
      guard = 0;
      while ((expw.size() != 0 || m_valid) && guard < 100) begin
         m_ready = 1'b1;
         #1;
         if (m_valid && expw.size() != 0) chk("drain_data", m_data, expw.pop_front());
         tick();
         guard++;
      end
      chk("rnd_all_beats_out", expw.size(), 0);
      #1;
`ifdef RFIFO_DRAIN_PERF_EN
      chk("rnd_stall_cnt", stall_cnt, stalls);
`else
      chk("rnd_stall_cnt", stall_cnt, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
